// File: rtl/decoder_1x4_sync.sv
// Registered 2-to-4 one-hot decoder: a select code is captured on a load strobe
// and decoded onto four enable lines, gated by a combinational output enable.
module decoder_1x4_sync #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [1:0] sel,
   input  logic       oe,
   output logic       out_0,
   output logic       out_1,
   output logic       out_2,
   output logic       out_3,
   output logic [1:0] sel_q,
   output logic       valid
);

   logic [1:0] sel_d;
   logic       valid_d;
   logic       valid_q;
   logic [3:0] hit;
   logic [3:0] out_vec;

   // sel is only looked at when load is high, so an unknown code on an idle
   // cycle never reaches the state registers.
   always_comb begin
      sel_d   = sel_q;
      valid_d = valid_q;
      if (load) begin
         sel_d   = sel;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q   <= 2'b00;
         valid_q <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         valid_q <= valid_d;
      end
   end

   // oe stays combinational so the downstream unit can be muted within a cycle.
   always_comb begin
      hit = 4'b0000;
      if (valid_q && oe) begin
         hit[sel_q] = 1'b1;
      end
   end

   assign out_vec = hit ^ {4{ACTIVE_LOW}};
   assign out_0   = out_vec[0];
   assign out_1   = out_vec[1];
   assign out_2   = out_vec[2];
   assign out_3   = out_vec[3];
   assign valid   = valid_q;

endmodule

// File: tb/tb_decoder_1x4_sync.sv
// Self-checking bench for decoder_1x4_sync: a table of clocked vectors plus
// hand-written sequences for hold, output enable and between-edge reset pulses.
module tb_decoder_1x4_sync;

   logic       clk;
   logic       rst;
   logic       load;
   logic [1:0] sel;
   logic       oe;
   logic       out_0, out_1, out_2, out_3;
   logic [1:0] sel_q;
   logic       valid;
   logic       n_out_0, n_out_1, n_out_2, n_out_3;
   logic [1:0] n_sel_q;
   logic       n_valid;

   int n_cmp;
   int n_bad;

   typedef struct {
      string      name;
      logic       rst;
      logic       load;
      logic [1:0] sel;
      logic       oe;
      logic [3:0] exp_out;
      logic [1:0] exp_sel_q;
      logic       exp_valid;
   } vec_t;

   vec_t vecs[$];

   decoder_1x4_sync #(.ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .load(load), .sel(sel), .oe(oe),
      .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
      .sel_q(sel_q), .valid(valid)
   );

   decoder_1x4_sync #(.ACTIVE_LOW(1'b1)) dut_n (
      .clk(clk), .rst(rst), .load(load), .sel(sel), .oe(oe),
      .out_0(n_out_0), .out_1(n_out_1), .out_2(n_out_2), .out_3(n_out_3),
      .sel_q(n_sel_q), .valid(n_valid)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Active-high instance must show exp_out, active-low instance its inverse.
   task automatic check(input string name, input logic [3:0] exp_out,
                        input logic [1:0] exp_sel_q, input logic exp_valid);
      cmp({name, " out"},    {4'b0, out_3, out_2, out_1, out_0}, {4'b0, exp_out});
      cmp({name, " out_n"},  {4'b0, n_out_3, n_out_2, n_out_1, n_out_0}, {4'b0, ~exp_out});
      cmp({name, " sel_q"},  {6'b0, sel_q}, {6'b0, exp_sel_q});
      cmp({name, " valid"},  {7'b0, valid}, {7'b0, exp_valid});
      cmp({name, " n_state"}, {5'b0, n_sel_q, n_valid}, {5'b0, exp_sel_q, exp_valid});
   endtask

   task automatic add_vec(input string name, input logic r, input logic l,
                          input logic [1:0] s, input logic o, input logic [3:0] eo,
                          input logic [1:0] es, input logic ev);
      vec_t v;
      v.name = name; v.rst = r; v.load = l; v.sel = s; v.oe = o;
      v.exp_out = eo; v.exp_sel_q = es; v.exp_valid = ev;
      vecs.push_back(v);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      load  = 1'b0;
      sel   = 2'b00;
      oe    = 1'b1;

      //       name            rst   load  sel    oe    out      sel_q  valid
      add_vec("reset_0",       1'b1, 1'b0, 2'b00, 1'b1, 4'b0000, 2'b00, 1'b0);
      add_vec("reset_1",       1'b1, 1'b0, 2'b10, 1'b1, 4'b0000, 2'b00, 1'b0);
      add_vec("idle_0",        1'b0, 1'b0, 2'b11, 1'b1, 4'b0000, 2'b00, 1'b0);
      add_vec("idle_1",        1'b0, 1'b0, 2'b01, 1'b1, 4'b0000, 2'b00, 1'b0);
      add_vec("sweep_00",      1'b0, 1'b1, 2'b00, 1'b1, 4'b0001, 2'b00, 1'b1);
      add_vec("sweep_01",      1'b0, 1'b1, 2'b01, 1'b1, 4'b0010, 2'b01, 1'b1);
      add_vec("sweep_10",      1'b0, 1'b1, 2'b10, 1'b1, 4'b0100, 2'b10, 1'b1);
      add_vec("sweep_11",      1'b0, 1'b1, 2'b11, 1'b1, 4'b1000, 2'b11, 1'b1);
      add_vec("reload_11",     1'b0, 1'b1, 2'b11, 1'b1, 4'b1000, 2'b11, 1'b1);
      add_vec("rst_over_load", 1'b1, 1'b1, 2'b11, 1'b1, 4'b0000, 2'b00, 1'b0);
      add_vec("post_rst_idle", 1'b0, 1'b0, 2'b11, 1'b1, 4'b0000, 2'b00, 1'b0);
      add_vec("rearm_01",      1'b0, 1'b1, 2'b01, 1'b1, 4'b0010, 2'b01, 1'b1);
      add_vec("load_oe_off",   1'b0, 1'b1, 2'b11, 1'b0, 4'b0000, 2'b11, 1'b1);
      add_vec("oe_back_on",    1'b0, 1'b0, 2'b00, 1'b1, 4'b1000, 2'b11, 1'b1);
      add_vec("load_10",       1'b0, 1'b1, 2'b10, 1'b1, 4'b0100, 2'b10, 1'b1);

      foreach (vecs[i]) begin
         rst  = vecs[i].rst;
         load = vecs[i].load;
         sel  = vecs[i].sel;
         oe   = vecs[i].oe;
         step();
         check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_sel_q, vecs[i].exp_valid);
      end

      // hold: 10 latched, sel wanders while load is low
      rst  = 1'b0;
      load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sel = 2'($urandom_range(0, 3));
         if (i == 2) sel = 2'bxx;
         step();
         check($sformatf("hold_%0d", i), 4'b0100, 2'b10, 1'b1);
      end

      // output enable: combinational gating with 01 latched
      load = 1'b1;
      sel  = 2'b01;
      step();
      load = 1'b0;
      check("oe_base", 4'b0010, 2'b01, 1'b1);
      oe = 1'b0;
      #1;
      check("oe_drop_same_cycle", 4'b0000, 2'b01, 1'b1);
      step();
      check("oe_drop_next_edge", 4'b0000, 2'b01, 1'b1);
      oe = 1'b1;
      #1;
      check("oe_restore", 4'b0010, 2'b01, 1'b1);

      // a reset pulse that never sees a rising edge must be ignored
      #1;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
      check("async_rst_pulse", 4'b0010, 2'b01, 1'b1);

      // back-to-back loads then reset in the middle of the run
      load = 1'b1;
      sel  = 2'b11;
      step();
      check("b2b_11", 4'b1000, 2'b11, 1'b1);
      sel = 2'b00;
      step();
      check("b2b_00", 4'b0001, 2'b00, 1'b1);
      rst = 1'b1;
      sel = 2'b10;
      step();
      check("b2b_rst", 4'b0000, 2'b00, 1'b0);
      rst = 1'b0;
      sel = 2'b11;
      step();
      check("b2b_rearm", 4'b1000, 2'b11, 1'b1);
      load = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decoder_1x4_sync.md
# decoder_1x4_sync

Registered 2-to-4 one-hot decoder. It latches a 2-bit select code on a load strobe and drives exactly one of four enable lines from the latched code. It sits in the datapath control of the video display processor, where it steers a single downstream unit (add/jump/update path select) from a decoded opcode field. The RTL module name is `decoder_1x4_sync`.

## Interface
Parameters:
- `ACTIVE_LOW`, default 0: output polarity. 0 means the selected line is 1 and the others are 0. 1 inverts all four outputs, including their reset and idle values.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: when high, capture `sel` at the next rising edge.
- `sel` in 2: select code. 00 selects `out_0`, 01 selects `out_1`, 10 selects `out_2`, 11 selects `out_3`.
- `oe` in 1: output enable. It is combinational and is not registered.
- `out_0`, `out_1`, `out_2`, `out_3` out 1 each: decoded lines.
- `sel_q` out 2: currently latched select code.
- `valid` out 1: high once a code has been loaded since the last reset.

## Operation
- State consists of `sel_q[1:0]` and `valid`, nothing else.
- Rising edge with `rst`=1: `sel_q`←00 and `valid`←0. `rst` has priority over `load`.
- Rising edge with `rst`=0 and `load`=1: `sel_q`←`sel` and `valid`←1.
- Rising edge with `rst`=0 and `load`=0: state holds.
- Logical decode, for n = 0..3: `hit_n` = `valid` & `oe` & (`sel_q` == n).
- Output: `out_n` = `hit_n` XOR `ACTIVE_LOW`.
- When `valid`=1 and `oe`=1, exactly one `hit_n` is 1 (one-hot).
- When `valid`=0 or `oe`=0, all `hit_n` are 0. With `ACTIVE_LOW`=0 all outputs are 0; with `ACTIVE_LOW`=1 all outputs are 1.
- Reloading the same code keeps the same output, with no glitch and no deassertion between cycles.
- X or Z on `sel` while `load`=0 has no effect.

## Timing
- Reset values: `sel_q`=00, `valid`=0, and all `out_n` inactive (0 for `ACTIVE_LOW`=0).
- Latency from `load` to outputs: 1 cycle. A code sampled at edge k appears on `out_n`, `sel_q` and `valid` immediately after edge k.
- `oe` to outputs: combinational, 0 cycles, with no register in the path.
- Back-to-back loads on consecutive cycles are allowed. Each edge's code is reflected right after that edge, and there is never a cycle with two lines active.
- `rst` asserted during a run of loads: after the reset edge all outputs are inactive, regardless of `load` in that cycle. The first edge with `rst`=0 and `load`=1 re-arms the block.
- `rst` is sampled only on a clock edge; an asynchronous `rst` pulse between edges has no effect.

## Test plan
- Reset then idle: assert `rst` for 2 cycles with `oe`=1. Required: all outputs 0, `valid`=0, `sel_q`=00, and they stay so while `load`=0.
- Exhaustive sweep: with `oe`=1, load `sel`=00, 01, 10, 11 on four consecutive edges. Required after each edge: `{out_3..out_0}` = 0001, 0010, 0100, 1000 respectively, and `sel_q` tracks the loaded code.
- Hold: load 10, then `load`=0 for 5 cycles while `sel` toggles randomly. Required: `out_2`=1 and the others 0 throughout.
- Output enable: with 01 latched, drop `oe` to 0. Required: all outputs 0 in the same cycle, and `out_1`=1 again as soon as `oe` returns to 1.
- Reset priority: `rst`=1 and `load`=1 with `sel`=11 on the same edge. Required: all outputs 0, `valid`=0, `sel_q`=00.
- Polarity: with `ACTIVE_LOW`=1, check all outputs are 1 after reset. After loading 11 with `oe`=1, required: `{out_3..out_0}` = 0111.
